// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: sequencer handshake, operand read ports and register-file write port.
interface alu_exec_unit_if;
  logic       start;
  logic [2:0] op;
  logic       dst;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic       busy;
  logic       done;
  logic       wr_en;
  logic       wr_reg;
  logic [7:0] wr_data;
  logic       zero;
  logic       carry;

  modport master (
    output start, op, dst, src_a, src_b,
    input  busy, done, wr_en, wr_reg, wr_data, zero, carry
  );

  modport slave (
    input  start, op, dst, src_a, src_b,
    output busy, done, wr_en, wr_reg, wr_data, zero, carry
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle 8-bit execute stage writing back to a 2-entry register file.
// Define ALU_MUL_EN to build the 8-cycle shift-add multiplier for op 110.
module alu_exec_unit (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL1  = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       dst_q, dst_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [8:0] res_q, res_d;
  logic       done_q, done_d;
  logic       wr_en_q, wr_en_d;
  logic       wr_reg_q, wr_reg_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic [8:0] alu_res;
  logic       write_ok;

`ifdef ALU_MUL_EN
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addend;
  logic [15:0] prod;
  assign write_ok = 1'b1;
`else
  // Without the multiplier, op 110 completes but must not write or touch flags.
  assign write_ok = (op_q != OP_MUL);
`endif

  // Bit 8 carries the flag: carry out, borrow, or shifted-out bit.
  always_comb begin
    alu_res = 9'd0;
    case (op_q)
      OP_ADD:   alu_res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:   alu_res = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:   alu_res = {1'b0, a_q & b_q};
      OP_OR:    alu_res = {1'b0, a_q | b_q};
      OP_XOR:   alu_res = {1'b0, a_q ^ b_q};
      OP_SHL1:  alu_res = {a_q[7], a_q[6:0], 1'b0};
      OP_PASSB: alu_res = {1'b0, b_q};
      default:  alu_res = 9'd0;
    endcase
  end

  always_comb begin
    // NOTE: every _d defaults to its _q (or to 0 for pulses) so no path infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
`ifdef ALU_MUL_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    addend    = 16'd0;
    prod      = 16'd0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          dst_d   = bus.dst;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          state_d = EXEC;
`ifdef ALU_MUL_EN
          acc_d   = 16'd0;
          cnt_d   = 3'd0;
`endif
        end
      end
      EXEC: begin
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          addend = b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0;
          prod   = acc_q + addend;
          acc_d  = prod;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            res_d   = {|prod[15:8], prod[7:0]};
            state_d = WB;
          end
        end else begin
          res_d   = alu_res;
          state_d = WB;
        end
`else
        res_d   = alu_res;
        state_d = WB;
`endif
      end
      WB: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (write_ok) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = dst_q;
          wr_data_d = res_q[7:0];
          zero_d    = (res_q[7:0] == 8'd0);
          carry_d   = res_q[8];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      dst_q     <= 1'b0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      res_q     <= 9'd0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 1'b0;
      wr_data_q <= 8'd0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q     <= 16'd0;
      cnt_q     <= 3'd0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
`ifdef ALU_MUL_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  // busy also covers the registered write cycle, so it never drops before wr_en does.
  assign bus.busy    = (state_q != IDLE) || done_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_reg  = wr_reg_q;
  assign bus.wr_data = wr_data_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit; honours ALU_MUL_EN the same way as the RTL.
module tb_alu_exec_unit;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL1  = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  logic clk = 1'b0;
  logic rst;

  alu_exec_unit_if bus();

  alu_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic       wr_reg;
    logic [7:0] data;
    logic       zero;
    logic       carry;
    logic [3:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   wr_cnt     = 0;
  int   exp_writes = 0;
  int   wr_before  = 0;

  logic       m_reg   = 1'b0;
  logic [7:0] m_data  = 8'd0;
  logic       m_zero  = 1'b0;
  logic       m_carry = 1'b0;

  logic [2:0] t_op [6] = '{OP_AND, OP_OR, OP_XOR, OP_SHL1, OP_PASSB, OP_SUB};
  logic [7:0] t_a  [6] = '{8'hF0, 8'h0F, 8'h5A, 8'h81, 8'h55, 8'h03};
  logic [7:0] t_b  [6] = '{8'h3C, 8'hF0, 8'h5A, 8'h00, 8'h00, 8'h05};

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result: bit 8 is the carry flag, bits 7:0 the written data.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), 8'(a - b)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_SHL1: return {a[7], a[6:0], 1'b0};
      OP_MUL: begin
        p = {8'd0, a} * {8'd0, b};
        return {|p[15:8], p[7:0]};
      end
      default: return {1'b0, b};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic dst, input logic [7:0] a,
                       input logic [7:0] b, input bit track);
    exp_t       e;
    logic [8:0] r;
    logic       legal;
    r     = model(op, a, b);
    legal = 1'b1;
`ifndef ALU_MUL_EN
    if (op == OP_MUL) legal = 1'b0;
`endif
    if (legal) begin
      m_reg   = dst;
      m_data  = r[7:0];
      m_zero  = (r[7:0] == 8'd0);
      m_carry = r[8];
    end
    e.wr_en  = legal;
    e.wr_reg = m_reg;
    e.data   = m_data;
    e.zero   = m_zero;
    e.carry  = m_carry;
    e.lat    = 4'd2;
`ifdef ALU_MUL_EN
    if (op == OP_MUL) e.lat = 4'd9;
`endif
    if (track) begin
      sb.push_back(e);
      if (legal) exp_writes++;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.dst   = dst;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit tail);
    exp_t e;
    bit   found = 1'b0;
    int   lat   = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1'b1;
        lat   = cyc;
        break;
      end
    end
    if (!found) begin
      check({tag, " done_timeout"}, 16'(bus.done), 16'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check({tag, " unexpected_done"}, 16'(bus.done), 16'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"}, 16'(lat),         16'(e.lat));
    check({tag, " wr_en"},   16'(bus.wr_en),   16'(e.wr_en));
    check({tag, " wr_reg"},  16'(bus.wr_reg),  16'(e.wr_reg));
    check({tag, " wr_data"}, 16'(bus.wr_data), 16'(e.data));
    check({tag, " zero"},    16'(bus.zero),    16'(e.zero));
    check({tag, " carry"},   16'(bus.carry),   16'(e.carry));
    check({tag, " busy"},    16'(bus.busy),    16'd1);
    if (tail) begin
      @(negedge clk);
      check({tag, " busy_after"},  16'(bus.busy),  16'd0);
      check({tag, " done_after"},  16'(bus.done),  16'd0);
      check({tag, " wr_en_after"}, 16'(bus.wr_en), 16'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},    16'(bus.busy),    16'd0);
    check({tag, " done"},    16'(bus.done),    16'd0);
    check({tag, " wr_en"},   16'(bus.wr_en),   16'd0);
    check({tag, " wr_reg"},  16'(bus.wr_reg),  16'd0);
    check({tag, " wr_data"}, 16'(bus.wr_data), 16'd0);
    check({tag, " zero"},    16'(bus.zero),    16'd0);
    check({tag, " carry"},   16'(bus.carry),   16'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.dst   = 1'b0;
    bus.src_a = 8'd0;
    bus.src_b = 8'd0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    repeat (10) @(negedge clk);
    check("idle_no_write", 16'(wr_cnt), 16'd0);
    check("idle_busy", 16'(bus.busy), 16'd0);

    issue(OP_ADD, 1'b1, 8'hF0, 8'h20, 1'b1);
    wait_done("add_f0_20", 1'b1);
    issue(OP_SUB, 1'b0, 8'h05, 8'h05, 1'b1);
    wait_done("sub_eq", 1'b1);

    // Each issue follows the previous done sample, so these run back to back.
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], i[0], t_a[i], t_b[i], 1'b1);
      wait_done($sformatf("tbl%0d", i), 1'b0);
    end

    // start held high across T1 and T2 must be ignored; the next start at T3 is taken.
    issue(OP_ADD, 1'b0, 8'h33, 8'h44, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_PASSB;
    bus.dst   = 1'b1;
    bus.src_b = 8'h77;
    wait_done("busy_ignore", 1'b0);
    issue(OP_XOR, 1'b1, 8'hAA, 8'hAA, 1'b1);
    wait_done("b2b_accept", 1'b1);
    check("write_count_mid", 16'(wr_cnt), 16'(exp_writes));

`ifdef ALU_MUL_EN
    issue(OP_MUL, 1'b1, 8'h13, 8'h0D, 1'b1);
    wait_done("mul_13_0d", 1'b1);
    issue(OP_MUL, 1'b0, 8'h20, 8'h10, 1'b1);
    wait_done("mul_20_10", 1'b1);
    issue(OP_MUL, 1'b1, 8'hFF, 8'hFF, 1'b1);
    wait_done("mul_ff_ff", 1'b1);
`else
    issue(OP_ADD, 1'b1, 8'hF0, 8'h20, 1'b1);
    wait_done("add_before_illegal", 1'b1);
    issue(OP_MUL, 1'b0, 8'h12, 8'h34, 1'b1);
    wait_done("illegal_mul", 1'b1);
`endif

    // Abort an operation in flight; the reset must clear outputs without a clock.
    wr_before = wr_cnt;
`ifdef ALU_MUL_EN
    issue(OP_MUL, 1'b1, 8'h13, 8'h0D, 1'b0);
    repeat (4) @(posedge clk);
`else
    issue(OP_ADD, 1'b1, 8'h01, 8'h02, 1'b0);
`endif
    #1 rst = 1'b1;
    #1 check_all_zero("rst_midop");
    m_reg   = 1'b0;
    m_data  = 8'd0;
    m_zero  = 1'b0;
    m_carry = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_no_write", 16'(wr_cnt), 16'(wr_before));

    issue(OP_ADD, 1'b0, 8'h7F, 8'h01, 1'b1);
    wait_done("post_rst_add", 1'b1);

    check("write_count_final", 16'(wr_cnt), 16'(exp_writes));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
